// File: rtl/uart_rx_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_capture_pkg
// Description : Shared definitions for the UART receive capture block:
//               receiver state encoding, parity mode constants and the
//               oversampling tick divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_capture_pkg;

    // Receiver state encoding, kept as explicit-width constants.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_PARITY  = 3'd3;
    localparam state_t ST_STOP    = 3'd4;
    localparam state_t ST_RECOVER = 3'd5;

    // Parity modes selectable through the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per oversampling tick; never below 1 so slow clocks still work.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_capture_fifo
// Description : First-word-fall-through FIFO with same-cycle push/pop
//               (honoured at full and at empty) and an occupancy count.
//               The head reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL);
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_capture
// Description : UART receive monitor. Decodes an oversampled serial line,
//               buffers accepted characters in a FWFT FIFO with a
//               valid/ready drain port, and flags end-of-run, framing,
//               parity and overflow conditions.
//               Optional macro UART_RX_CAPTURE_PRINT_EN: echoes every byte
//               accepted into the FIFO to the simulation console.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_capture
    import uart_rx_capture_pkg::*;
#(
    parameter int         CLK_HZ      = 50000000,
    parameter int         BAUD        = 115200,
    parameter int         OVERSAMPLE  = 16,
    parameter int         DATA_BITS   = 8,
    parameter int         PARITY      = 0,
    parameter int         STOP_BITS   = 1,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] FINISH_CHAR = 8'h04,
    parameter logic [7:0] DROP_CHAR   = 8'h0D
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          core_finish,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow
);

    localparam int c_DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    state_t               r_state;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_OS_W-1:0]    r_os_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_par_bit;
    logic                 r_stop_bad;
    logic                 r_push_valid;
    logic [7:0]           r_push_data;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_finish;
    logic                 r_overflow;

    logic                 w_tick;
    logic                 w_sample;
    logic [c_OS_W-1:0]    w_os_target;
    logic                 w_stop_bad;
    logic                 w_par_bad;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign uart_tx     = 1'b1;
    assign core_finish = r_finish;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overflow    = r_overflow;
    assign out_valid   = !w_fifo_empty;

    // Bit sampling happens mid-bit: half a bit into START, a full bit after that.
    assign w_tick      = (r_div_cnt == c_DIV_W'(c_DIV - 1));
    assign w_os_target = (r_state == ST_START) ? c_OS_W'(OVERSAMPLE/2 - 1)
                                               : c_OS_W'(OVERSAMPLE - 1);
    assign w_sample    = w_tick && (r_os_cnt == w_os_target);
    assign w_stop_bad  = r_stop_bad | ~r_rx_sync;

    assign w_pop    = out_ready && out_valid;
    assign w_accept = r_push_valid && (!w_fifo_full || w_pop);

    // Parity check of the collected data bits against the received parity bit.
    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY == PARITY_ODD) begin
            w_par_bad = ~((^r_shift) ^ r_par_bit);
        end else if (PARITY == PARITY_EVEN) begin
            w_par_bad = (^r_shift) ^ r_par_bit;
        end
    end

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Frame decoder: tick divider, bit sampling and frame-completion decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_push_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_sample) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + c_OS_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    // Hold the divider cleared so sampling aligns to the falling edge.
                    r_div_cnt <= '0;
                    r_os_cnt  <= '0;
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (r_rx_sync) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= r_rx_sync;
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            r_bit_cnt  <= '0;
                            r_stop_bad <= 1'b0;
                            r_state    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= r_rx_sync;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        if (r_bit_cnt == 3'(STOP_BITS - 1)) begin
                            if (w_stop_bad) begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_RECOVER;
                            end else begin
                                r_state <= ST_IDLE;
                                if ((PARITY != PARITY_NONE) && w_par_bad) begin
                                    r_parity_err <= 1'b1;
                                end else if (r_shift == FINISH_CHAR) begin
                                    r_finish <= 1'b1;
                                end else if (r_shift != DROP_CHAR) begin
                                    r_push_valid <= 1'b1;
                                    r_push_data  <= r_shift;
                                end
                            end
                        end else begin
                            r_stop_bad <= w_stop_bad;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    // A broken frame may leave the line low; wait for idle first.
                    if (r_rx_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky loss flag: a completed byte found the FIFO full with no pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (r_push_valid && !w_accept) begin
            r_overflow <= 1'b1;
        end
    end

    uart_rx_capture_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push_valid),
        .push_data (r_push_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

`ifdef UART_RX_CAPTURE_PRINT_EN
    // Echo each byte as it is accepted into the FIFO.
    always @(posedge clk) begin
        if (!rst && w_accept) begin
            $write("%c", r_push_data);
        end
    end
`else
    // Console echo compiled out; capture and handshake are unchanged.
`endif

endmodule
`default_nettype wire
